freq_meas_sched: RTL and testbench
==================================

// Module: freq_meas_sched
// PURPOSE
//  Round-robin scheduler for one shared frequency-measurement counter across NUM_CH clock sources.
//  Runs in the reference clock domain CLK. For each enabled channel it:
//  - drives the source mux select;
//  - waits for the mux to settle;
//  - opens a gate window of GATE_CYCLES;
//  - waits for the counter's result handshake;
//  - stores the result per channel for readback.
// PARAMETERS
//  NUM_CH         4     number of measured channels (2..16)
//  CH_W           2     channel index width, clog2(NUM_CH)
//  CNT_W          16    result width
//  SETTLE_CYCLES  16    CLK cycles between CH_SEL change and gate open (>=1)
//  GATE_CYCLES    1000  gate window length in CLK cycles (>=2)
//  TIMEOUT_CYCLES 64    max CLK cycles to wait for result after gate close
// PORTS
//  CLK         in   1       reference clock
//  RESET       in   1       reset, asynchronous, active-high
//  ENABLE      in   1       level; 1 = run scan continuously
//  CH_MASK     in   NUM_CH  bit i = 1 -> channel i included in scan
//  CH_SEL      out  CH_W    source mux select to measurement counter
//  GATE        out  1       count window (DE-mode gate) to measurement counter
//  RES_TOGGLE  in   1       async; counter toggles once per new result
//  RES_IN      in   CNT_W   async; counter result, stable >=4 CLK after toggle
//  RD_CH       in   CH_W    readback channel index
//  RD_DATA     out  CNT_W   stored result of RD_CH (combinational read)
//  RD_VALID    out  1       1 = RD_CH holds a fresh result (not timed out)
//  LIM_LO      in   CNT_W   lower alarm limit (inclusive)
//  LIM_HI      in   CNT_W   upper alarm limit (inclusive)
//  ALARM       out  NUM_CH  per-channel out-of-range flag
//  CYCLE_DONE  out  1       1-CLK pulse after last enabled channel of a scan is stored
//  BUSY        out  1       1 whenever FSM not in IDLE
// BEHAVIOUR
//  Reset values:
//  - all outputs 0; FSM IDLE; result RAM 0; valid bits 0; channel pointer 0.
//  Synchronisation:
//  - RES_TOGGLE passes through a 3-FF synchroniser; edge = ff[2]^ff[1].
//  - RES_IN is registered on the CLK after the edge is detected.
//  - Toggles arriving outside WAIT_RES are ignored; edge detector still tracks them.
//  FSM states:
//  - IDLE: if ENABLE && |CH_MASK, pick the lowest set mask bit at or after the pointer (wrapping) -> SETTLE.
//    CH_SEL updates on this transition.
//  - SETTLE: count SETTLE_CYCLES -> GATE.
//  - GATE: GATE=1 for exactly GATE_CYCLES CLK cycles -> WAIT_RES (GATE=0).
//  - WAIT_RES: on sync edge -> STORE. If TIMEOUT_CYCLES elapse -> STORE with timeout flag.
//  - STORE (1 cycle), normal: ram[ch]<=RES_IN_reg, valid[ch]<=1.
//  - STORE, on timeout: ram[ch] keeps its value, valid[ch]<=0.
//  - STORE, channel advance: move to next enabled channel (wrap NUM_CH-1 -> 0).
//  - STORE, end of scan: if that channel is the highest enabled index, pulse CYCLE_DONE.
//  - STORE, next state: IDLE when ENABLE==0, else SETTLE on the next channel.
//  Scan rules:
//  - ENABLE deassert mid-channel: current channel completes through STORE, then IDLE.
//  - CH_MASK changes take effect at the next channel selection; the current channel always completes.
//  - CH_MASK==0 with ENABLE=1: stay IDLE, BUSY=0.
//  - Single enabled channel: re-measured back to back; CYCLE_DONE pulses every STORE.
//  - Per-channel time: 1+SETTLE+GATE+sync latency(<=TIMEOUT)+1 CLK.
//  Readback:
//  - RD_DATA/RD_VALID are a combinational read of ram/valid[RD_CH].
//  - RD_CH >= NUM_CH -> RD_DATA=0, RD_VALID=0.
// CONFIGURATION
//  FREQ_SCHED_LIMIT_CHECK_EN defined:
//  - In STORE, ALARM[ch] <= timeout | (RES_IN_reg < LIM_LO) | (RES_IN_reg > LIM_HI).
//  - ALARM stays registered until that channel's next STORE.
//  - LIM_LO > LIM_HI flags every channel.
//  FREQ_SCHED_LIMIT_CHECK_EN undefined:
//  - ALARM tied to 0; LIM_LO/LIM_HI unused; no comparators built.
// TESTING
//  T1 Basic scan. NUM_CH=4, mask=4'b1111, model returns 100*(ch+1) 10 CLK after gate close.
//     -> CH_SEL sequence 0,1,2,3,0; RD_DATA ch2=300, RD_VALID=1; CYCLE_DONE after ch3 store.
//  T2 Sparse mask. mask=4'b1010.
//     -> CH_SEL alternates 1,3; ch0/ch2 RD_VALID stay 0; GATE high exactly 1000 CLK per channel.
//  T3 Timeout. Model never toggles on ch1.
//     -> WAIT_RES exits after 64 CLK; ch1 RD_VALID=0, data unchanged; scan continues with ch2.
//  T4 Enable drop. ENABLE=0 during GATE of ch2.
//     -> ch2 stored; FSM IDLE; BUSY=0; no CH_SEL change. Re-enable resumes at ch3.
//  T5 Limits (macro on). LIM_LO=150, LIM_HI=350, results 100/200/300/400.
//     -> ALARM=4'b1001. Macro off -> ALARM=0.
//  T6 Async reset mid-WAIT_RES. Then a stray toggle.
//     -> all outputs 0 immediately; stray toggle ignored; first result stored only after a fresh gate.

Source files
------------

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin scheduler sharing one frequency-measurement counter across NUM_CH sources.
// Define FREQ_SCHED_LIMIT_CHECK_EN to build the per-channel out-of-range alarm comparators.
module freq_meas_sched #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int CNT_W          = 16,
    parameter int SETTLE_CYCLES  = 16,
    parameter int GATE_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [NUM_CH-1:0] CH_MASK,
    output logic [CH_W-1:0]   CH_SEL,
    output logic              GATE,
    input  logic              RES_TOGGLE,
    input  logic [CNT_W-1:0]  RES_IN,
    input  logic [CH_W-1:0]   RD_CH,
    output logic [CNT_W-1:0]  RD_DATA,
    output logic              RD_VALID,
    input  logic [CNT_W-1:0]  LIM_LO,
    input  logic [CNT_W-1:0]  LIM_HI,
    output logic [NUM_CH-1:0] ALARM,
    output logic              CYCLE_DONE,
    output logic              BUSY
);

    localparam int TMR_W = $clog2(GATE_CYCLES + SETTLE_CYCLES + TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_WAIT,
        S_STORE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic               gate_q, gate_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   res_q, res_d;
    logic [2:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   ram_q [NUM_CH];
    logic [CNT_W-1:0]   ram_d [NUM_CH];
    logic [NUM_CH-1:0]  valid_q, valid_d;
    logic               res_edge;

    // Lowest enabled channel at or after start, wrapping past NUM_CH-1.
    function automatic logic [CH_W-1:0] pick_ch(input logic [NUM_CH-1:0] mask,
                                                 input logic [CH_W-1:0] start);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(start) + i) % NUM_CH;
            if (!found && mask[idx]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [CH_W-1:0] last_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                sel = CH_W'(i);
            end
        end
        return sel;
    endfunction

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] ch);
        return (int'(ch) == NUM_CH - 1) ? '0 : ch + CH_W'(1);
    endfunction

    assign res_edge = sync_q[2] ^ sync_q[1];

`ifdef FREQ_SCHED_LIMIT_CHECK_EN
    logic [NUM_CH-1:0] alarm_q, alarm_d;
    assign ALARM = alarm_q;
`else
    logic lim_unused;
    assign ALARM      = '0;
    assign lim_unused = ^{LIM_LO, LIM_HI};
`endif

    always_comb begin
        sync_d    = {sync_q[1:0], RES_TOGGLE};
        state_d   = state_q;
        tmr_d     = tmr_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        res_d     = res_q;
        ram_d     = ram_q;
        valid_d   = valid_q;
`ifdef FREQ_SCHED_LIMIT_CHECK_EN
        alarm_d   = alarm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ENABLE && |CH_MASK) begin
                    ch_d    = pick_ch(CH_MASK, ptr_q);
                    tmr_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    gate_d  = 1'b1;
                    state_d = S_GATE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_GATE: begin
                if (tmr_q == TMR_W'(GATE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    gate_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT: begin
                // A result edge wins over a timeout landing on the same cycle.
                if (res_edge) begin
                    res_d     = RES_IN;
                    timeout_d = 1'b0;
                    state_d   = S_STORE;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_STORE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_STORE: begin
                if (!timeout_q) begin
                    ram_d[ch_q] = res_q;
                end
                valid_d[ch_q] = !timeout_q;
`ifdef FREQ_SCHED_LIMIT_CHECK_EN
                alarm_d[ch_q] = timeout_q | (res_q < LIM_LO) | (res_q > LIM_HI);
`endif
                done_d = |CH_MASK && (ch_q == last_ch(CH_MASK));
                ptr_d  = wrap_inc(ch_q);
                tmr_d  = '0;
                if (ENABLE && |CH_MASK) begin
                    ch_d    = pick_ch(CH_MASK, wrap_inc(ch_q));
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            ch_q      <= '0;
            ptr_q     <= '0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            res_q     <= '0;
            sync_q    <= '0;
            ram_q     <= '{default: '0};
            valid_q   <= '0;
`ifdef FREQ_SCHED_LIMIT_CHECK_EN
            alarm_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            res_q     <= res_d;
            sync_q    <= sync_d;
            ram_q     <= ram_d;
            valid_q   <= valid_d;
`ifdef FREQ_SCHED_LIMIT_CHECK_EN
            alarm_q   <= alarm_d;
`endif
        end
    end

    always_comb begin
        RD_DATA  = '0;
        RD_VALID = 1'b0;
        if (int'(RD_CH) < NUM_CH) begin
            RD_DATA  = ram_q[RD_CH];
            RD_VALID = valid_q[RD_CH];
        end
    end

    assign CH_SEL     = ch_q;
    assign GATE       = gate_q;
    assign BUSY       = busy_q;
    assign CYCLE_DONE = done_q;

endmodule

// File: tb/tb_freq_meas_sched.sv
// tb_freq_meas_sched: directed scan scenarios with a behavioural counter model feeding a result scoreboard.
module tb_freq_meas_sched;

    localparam int GATE_CYCLES    = 1000;
    localparam int SETTLE_CYCLES  = 16;
    localparam int TIMEOUT_CYCLES = 64;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [3:0]  CH_MASK;
    logic [1:0]  CH_SEL;
    logic        GATE;
    logic        RES_TOGGLE;
    logic [15:0] RES_IN;
    logic [1:0]  RD_CH;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic [15:0] LIM_LO;
    logic [15:0] LIM_HI;
    logic [3:0]  ALARM;
    logic        CYCLE_DONE;
    logic        BUSY;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_ram [4];
    logic [3:0]  exp_alarm;
    logic [3:0]  no_resp;
    int          n_cmp;
    int          n_err;
    int          cd_count;
    int          cd_mark;
    int          waited;
    logic [1:0]  m_ch;
    logic [15:0] m_val;

    freq_meas_sched dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .CH_MASK    (CH_MASK),
        .CH_SEL     (CH_SEL),
        .GATE       (GATE),
        .RES_TOGGLE (RES_TOGGLE),
        .RES_IN     (RES_IN),
        .RD_CH      (RD_CH),
        .RD_DATA    (RD_DATA),
        .RD_VALID   (RD_VALID),
        .LIM_LO     (LIM_LO),
        .LIM_HI     (LIM_HI),
        .ALARM      (ALARM),
        .CYCLE_DONE (CYCLE_DONE),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (CYCLE_DONE === 1'b1) cd_count++;
    end

    // Counter model: on each gate close, answer 100*(ch+1) ten clocks later unless the channel is muted.
    always begin
        @(negedge GATE);
        if (RESET === 1'b0) begin
            m_ch = CH_SEL;
            if (no_resp[m_ch]) begin
                sb.push_back('{m_ch, exp_ram[m_ch], 1'b0});
                exp_alarm[m_ch] = 1'b1;
            end else begin
                m_val = 16'(100 * (int'(m_ch) + 1));
                sb.push_back('{m_ch, m_val, 1'b1});
                exp_ram[m_ch]   = m_val;
                exp_alarm[m_ch] = (m_val < LIM_LO) || (m_val > LIM_HI);
                repeat (10) @(posedge CLK);
                #1;
                RES_IN     = m_val;
                RES_TOGGLE = ~RES_TOGGLE;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] expected_alarm();
`ifdef FREQ_SCHED_LIMIT_CHECK_EN
        return exp_alarm;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic check_pending();
        exp_t e;
        bit   any;
        any = 1'b0;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            any = 1'b1;
            RD_CH = e.ch;
            #1;
            checkOutput($sformatf("rd_data ch%0d", e.ch), 32'(RD_DATA), 32'(e.data));
            checkOutput($sformatf("rd_valid ch%0d", e.ch), 32'(RD_VALID), 32'(e.valid));
        end
        if (any) checkOutput("alarm", 32'(ALARM), 32'(expected_alarm()));
    endtask

    // Wait for the next gate, settle the scoreboard, then measure the gate width.
    task automatic applyStimulus(input logic [1:0] exp_ch, input int drop_at);
        int high;
        waited = 0;
        high   = 0;
        while (GATE !== 1'b1 && waited < 5000) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("gate open in budget", 32'(waited < 5000), 32'd1);
        check_pending();
        checkOutput($sformatf("ch_sel exp %0d", exp_ch), 32'(CH_SEL), 32'(exp_ch));
        while (GATE === 1'b1 && high < 2000) begin
            high++;
            if (high == drop_at) ENABLE = 1'b0;
            @(negedge CLK);
        end
        checkOutput("gate width", 32'(high), 32'(GATE_CYCLES));
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RESET  = 1'b1;
        ENABLE = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        exp_ram   = '{default: '0};
        exp_alarm = '0;
        repeat (20) @(negedge CLK);
    endtask

    initial begin
        int b;
        n_cmp      = 0;
        n_err      = 0;
        cd_count   = 0;
        RESET      = 1'b1;
        ENABLE     = 1'b0;
        CH_MASK    = 4'b1111;
        RES_TOGGLE = 1'b0;
        RES_IN     = '0;
        RD_CH      = 2'd0;
        LIM_LO     = 16'd150;
        LIM_HI     = 16'd350;
        no_resp    = 4'b0000;
        exp_ram    = '{default: '0};
        exp_alarm  = '0;

        repeat (3) @(negedge CLK);
        checkOutput("reset ch_sel", 32'(CH_SEL), 32'd0);
        checkOutput("reset gate", 32'(GATE), 32'd0);
        checkOutput("reset busy", 32'(BUSY), 32'd0);
        checkOutput("reset cycle_done", 32'(CYCLE_DONE), 32'd0);
        checkOutput("reset alarm", 32'(ALARM), 32'd0);
        checkOutput("reset rd_data", 32'(RD_DATA), 32'd0);
        checkOutput("reset rd_valid", 32'(RD_VALID), 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] T1 basic scan");
        cd_mark = cd_count;
        ENABLE  = 1'b1;
        applyStimulus(2'd0, -1);
        applyStimulus(2'd1, -1);
        applyStimulus(2'd2, -1);
        applyStimulus(2'd3, -1);
        applyStimulus(2'd0, -1);
        checkOutput("t1 cycle_done count", 32'(cd_count - cd_mark), 32'd1);
        RD_CH = 2'd2;
        #1;
        checkOutput("t1 ch2 data", 32'(RD_DATA), 32'd300);
        checkOutput("t1 ch2 valid", 32'(RD_VALID), 32'd1);

        $display("[TB] T2 sparse mask");
        reset_dut();
        cd_mark = cd_count;
        CH_MASK = 4'b1010;
        ENABLE  = 1'b1;
        applyStimulus(2'd1, -1);
        applyStimulus(2'd3, -1);
        applyStimulus(2'd1, -1);
        applyStimulus(2'd3, -1);
        checkOutput("t2 cycle_done count", 32'(cd_count - cd_mark), 32'd1);
        RD_CH = 2'd0;
        #1;
        checkOutput("t2 ch0 valid", 32'(RD_VALID), 32'd0);
        RD_CH = 2'd2;
        #1;
        checkOutput("t2 ch2 valid", 32'(RD_VALID), 32'd0);

        $display("[TB] T3 timeout on ch1");
        CH_MASK = 4'b1111;
        no_resp = 4'b0010;
        applyStimulus(2'd0, -1);
        applyStimulus(2'd1, -1);

        $display("[TB] T4 enable drop during ch2 gate");
        applyStimulus(2'd2, 100);
        checkOutput("t3 timeout path length", 32'(waited), 32'(TIMEOUT_CYCLES + 1 + SETTLE_CYCLES));
        no_resp = 4'b0000;
        b = 0;
        while (BUSY !== 1'b0 && b < 200) begin
            @(negedge CLK);
            b++;
        end
        checkOutput("t4 idle in budget", 32'(b < 200), 32'd1);
        check_pending();
        checkOutput("t4 busy", 32'(BUSY), 32'd0);
        checkOutput("t4 ch_sel held", 32'(CH_SEL), 32'd2);
        repeat (20) @(negedge CLK);
        checkOutput("t4 ch_sel still held", 32'(CH_SEL), 32'd2);
        checkOutput("t4 still idle", 32'(BUSY), 32'd0);
        ENABLE = 1'b1;
        applyStimulus(2'd3, -1);
        applyStimulus(2'd0, -1);

        $display("[TB] T6 async reset in wait_res");
        RD_CH = 2'd0;
        repeat (3) @(negedge CLK);
        #2;
        RESET  = 1'b1;
        ENABLE = 1'b0;
        #1;
        checkOutput("t6 busy", 32'(BUSY), 32'd0);
        checkOutput("t6 gate", 32'(GATE), 32'd0);
        checkOutput("t6 ch_sel", 32'(CH_SEL), 32'd0);
        checkOutput("t6 alarm", 32'(ALARM), 32'd0);
        checkOutput("t6 rd_data", 32'(RD_DATA), 32'd0);
        checkOutput("t6 rd_valid", 32'(RD_VALID), 32'd0);
        sb.delete();
        exp_ram   = '{default: '0};
        exp_alarm = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        checkOutput("t6 stray toggle idle", 32'(BUSY), 32'd0);
        for (int i = 0; i < 4; i++) begin
            RD_CH = 2'(i);
            #1;
            checkOutput($sformatf("t6 valid ch%0d", i), 32'(RD_VALID), 32'd0);
        end
        RD_CH  = 2'd0;
        ENABLE = 1'b1;
        applyStimulus(2'd0, -1);
        applyStimulus(2'd1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
